// File: rtl/aes_kexp_pkg.sv
// Shared types, mode constants and GF(2^8) helper for the multi-length AES key expander.
package aes_kexp_pkg;

    typedef enum logic [1:0] {
        KL128 = 2'd0,
        KL192 = 2'd1,
        KL256 = 2'd2,
        KLBAD = 2'd3
    } key_len_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN,
        ST_SWAIT,
        ST_DONE
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [3:0] NK_256    = 4'd8;

    function automatic logic [3:0] nk_of(input key_len_e kl);
        case (kl)
            KL192:   return 4'd6;
            KL256:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e kl);
        case (kl)
            KL192:   return 4'd12;
            KL256:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] words_of(input key_len_e kl);
        case (kl)
            KL192:   return 6'd52;
            KL256:   return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_kexp_temp.sv
// Combinational temp-word builder: word classification, RotWord mux and rcon injection.
module aes_kexp_temp
    import aes_kexp_pkg::*;
(
    input  logic [31:0] i_w_prev,
    input  logic [31:0] i_w_back,
    input  logic [31:0] i_sub_out,
    input  logic [7:0]  i_rcon,
    input  logic [3:0]  i_j,
    input  logic [3:0]  i_nk,
    output logic        o_need_sbox,
    output logic        o_is_rot,
    output logic [31:0] o_sub_in,
    output logic [31:0] o_word_plain,
    output logic [31:0] o_word_sbox
);

    logic w_is_rot;
    logic w_is_sub256;

    // i_j carries i mod NK, maintained as a counter by the caller
    assign w_is_rot     = (i_j == 4'd0);
    assign w_is_sub256  = (i_nk == NK_256) && (i_j == 4'd4);
    assign o_is_rot     = w_is_rot;
    assign o_need_sbox  = w_is_rot | w_is_sub256;
    assign o_sub_in     = w_is_rot ? {i_w_prev[23:0], i_w_prev[31:24]} : i_w_prev;
    assign o_word_plain = i_w_back ^ i_w_prev;
    assign o_word_sbox  = i_w_back ^ i_sub_out ^ (w_is_rot ? {i_rcon, 24'h0} : 32'h0);

endmodule

// File: rtl/aes_key_expand_multi.sv
// Sequential AES-128/192/256 key schedule over a shared fixed-latency S-box port.
// Optional round-key streaming outputs under `AES_KEYEXP_STREAM_EN.
module aes_key_expand_multi
    import aes_kexp_pkg::*;
#(
    parameter int SBOX_LAT  = 1,
    parameter int MAX_WORDS = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         key_ready,
    output logic [3:0]   num_rounds,
    output logic         sub_valid,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data
`ifdef AES_KEYEXP_STREAM_EN
    ,
    output logic         rk_valid,
    output logic [3:0]   rk_num,
    output logic [127:0] rk_stream
`endif
);

    localparam logic [1:0] LAT_LAST = 2'(SBOX_LAT - 1);

    state_e      r_state, w_state_nxt;
    key_len_e    r_mode;
    logic [5:0]  r_i;
    logic [3:0]  r_j;
    logic [7:0]  r_rcon;
    logic [1:0]  r_lat;
    logic        r_busy, r_done, r_err, r_key_ready;
    logic [31:0] r_w [MAX_WORDS];

    logic [3:0]  w_nk;
    logic [5:0]  w_total;
    logic        w_last, w_kl_ok, w_sub_req, w_wr;
    logic [5:0]  w_ip, w_ib;
    logic        w_need_sbox, w_is_rot;
    logic [31:0] w_sub_in, w_word_plain, w_word_sbox, w_wdata;
    logic [31:0] w_keyw [8];

    assign w_nk    = nk_of(r_mode);
    assign w_total = words_of(r_mode);
    assign w_last  = (r_i == w_total - 6'd1);
    assign w_kl_ok = (key_len_e'(key_len) != KLBAD);
    assign w_ip    = r_i - 6'd1;
    assign w_ib    = r_i - {2'b00, w_nk};
    assign w_keyw  = '{key[255:224], key[223:192], key[191:160], key[159:128],
                       key[127:96],  key[95:64],   key[63:32],   key[31:0]};

    aes_kexp_temp u_temp (
        .i_w_prev     (r_w[w_ip]),
        .i_w_back     (r_w[w_ib]),
        .i_sub_out    (sub_out),
        .i_rcon       (r_rcon),
        .i_j          (r_j),
        .i_nk         (w_nk),
        .o_need_sbox  (w_need_sbox),
        .o_is_rot     (w_is_rot),
        .o_sub_in     (w_sub_in),
        .o_word_plain (w_word_plain),
        .o_word_sbox  (w_word_sbox)
    );

    assign w_wdata = (r_state == ST_SWAIT) ? w_word_sbox : w_word_plain;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sub_req   = 1'b0;
        w_wr        = 1'b0;
        unique case (r_state)
            ST_IDLE:  if (start && w_kl_ok) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_GEN;
            ST_GEN: begin
                if (w_need_sbox) begin
                    w_sub_req   = 1'b1;
                    w_state_nxt = ST_SWAIT;
                end else begin
                    w_wr        = 1'b1;
                    w_state_nxt = w_last ? ST_DONE : ST_GEN;
                end
            end
            ST_SWAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_wr        = 1'b1;
                    w_state_nxt = w_last ? ST_DONE : ST_GEN;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= KL128;
            r_i         <= '0;
            r_j         <= '0;
            r_rcon      <= RCON_INIT;
            r_lat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_key_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_kl_ok) begin
                        r_err <= 1'b1;
                    end else if (start) begin
                        r_mode      <= key_len_e'(key_len);
                        r_key_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_i    <= {2'b00, w_nk};
                    r_j    <= '0;
                    r_rcon <= RCON_INIT;
                end
                default: ;
            endcase
            if (w_sub_req)                r_lat <= '0;
            else if (r_state == ST_SWAIT) r_lat <= r_lat + 2'd1;
            if (w_wr) begin
                r_i <= r_i + 6'd1;
                r_j <= (r_j == w_nk - 4'd1) ? 4'd0 : r_j + 4'd1;
                if (r_state == ST_SWAIT && w_is_rot) r_rcon <= xtime(r_rcon);
                if (w_last) begin
                    r_done      <= 1'b1;
                    r_key_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            end
        end
    end

    // Word array is deliberately never cleared; writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_LOAD) begin
                for (int unsigned k = 0; k < 8; k++)
                    if (4'(k) < w_nk) r_w[6'(k)] <= w_keyw[3'(k)];
            end else if (w_wr) begin
                r_w[r_i] <= w_wdata;
            end
        end
    end

    always_comb begin
        rk_data = '0;
        if (rk_idx <= num_rounds)
            for (int unsigned k = 0; k < 4; k++)
                rk_data[127 - 32*k -: 32] = r_w[{rk_idx, 2'b00} + 6'(k)];
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign key_ready  = r_key_ready;
    assign num_rounds = nr_of(r_mode);
    assign sub_valid  = w_sub_req;
    assign sub_in     = w_sub_req ? w_sub_in : '0;

`ifdef AES_KEYEXP_STREAM_EN
    logic [3:0] r_rk_next;
    logic       w_rk_active;

    // Emit the next round key once its last word is in the array; LOAD can
    // complete two keys at once, so they drain one per cycle.
    assign w_rk_active = (r_state == ST_GEN) || (r_state == ST_SWAIT) || (r_state == ST_DONE);
    assign rk_valid    = w_rk_active && ({r_rk_next, 2'b11} < r_i);
    assign rk_num      = r_rk_next;

    always_comb begin
        rk_stream = '0;
        for (int unsigned k = 0; k < 4; k++)
            rk_stream[127 - 32*k -: 32] = r_w[{r_rk_next, 2'b00} + 6'(k)];
    end

    always_ff @(posedge clk) begin
        if (reset)                  r_rk_next <= '0;
        else if (r_state == ST_LOAD) r_rk_next <= '0;
        else if (rk_valid)          r_rk_next <= r_rk_next + 4'd1;
    end
`endif

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Self-checking bench for aes_key_expand_multi: reference key schedule, S-box pipeline model, scoreboard.
module tb_aes_key_expand_multi #(parameter int LAT = 1);

    logic         clk, reset, start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy, done, err, key_ready, sub_valid;
    logic [3:0]   num_rounds, rk_idx;
    logic [31:0]  sub_in, sub_out;
    logic [127:0] rk_data;
`ifdef AES_KEYEXP_STREAM_EN
    logic         rk_valid;
    logic [3:0]   rk_num;
    logic [127:0] rk_stream;
`endif

    aes_key_expand_multi #(.SBOX_LAT(LAT), .MAX_WORDS(60)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .key_ready  (key_ready),
        .num_rounds (num_rounds),
        .sub_valid  (sub_valid),
        .sub_in     (sub_in),
        .sub_out    (sub_out),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
`ifdef AES_KEYEXP_STREAM_EN
        ,
        .rk_valid   (rk_valid),
        .rk_num     (rk_num),
        .rk_stream  (rk_stream)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int sv_cnt = 0;
    int st_cnt = 0;

    logic [7:0]   sb [256];
    logic [7:0]   rc [10];
    logic [31:0]  refw [60];
    int           rnk, rnr;
    logic [127:0] sbq [$];
    logic [131:0] stq [$];

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        int           nsb;
        logic [3:0]   idx;
        logic [127:0] rk;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // External S-box: LAT-deep pipeline
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= subw(sub_in);
        for (int n = 1; n < LAT; n++) pipe[n] <= pipe[n-1];
    end
    assign sub_out = pipe[LAT-1];

    always @(negedge clk) begin
        if (sub_valid) begin
            sv_cnt++;
            chk("sub_valid_while_busy", busy, 1);
        end
`ifdef AES_KEYEXP_STREAM_EN
        if (rk_valid) begin
            st_cnt++;
            if (stq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stream_unexpected: got rk_num %0d expected no pulse", rk_num);
            end else begin
                chk("stream", {rk_num, rk_stream}, stq.pop_front());
            end
        end
`endif
    end

    task automatic ref_expand(input logic [1:0] kl, input logic [255:0] k);
        logic [255:0] tmp;
        logic [31:0]  t;
        int           total;
        rnk   = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
        rnr   = rnk + 6;
        total = 4 * (rnr + 1);
        for (int i = 0; i < rnk; i++) begin
            tmp     = k << (32 * i);
            refw[i] = tmp[255:224];
        end
        for (int i = rnk; i < total; i++) begin
            t = refw[i-1];
            if (i % rnk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rc[i/rnk - 1], 24'h0};
            else if (rnk == 8 && i % rnk == 4)
                t = subw(t);
            refw[i] = refw[i-rnk] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_of(input int r);
        return {refw[4*r], refw[4*r+1], refw[4*r+2], refw[4*r+3]};
    endfunction

    task automatic run_and_check(input vec_t v, input bit poke);
        int cyc, nr, gen, exp_cyc;
        bit err_seen;
        ref_expand(v.kl, v.key);
        nr = rnr;
        for (int r = 0; r <= nr; r++) begin
            sbq.push_back(rk_of(r));
            stq.push_back({4'(r), rk_of(r)});
        end
        gen     = 4 * (nr + 1) - rnk;
        exp_cyc = 1 + (gen - v.nsb) + v.nsb * (1 + LAT);
        sv_cnt = 0;
        st_cnt = 0;
        err_seen = 1'b0;
        @(negedge clk);
        key_len = v.kl;
        key     = v.key;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_accept", busy, 1);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 5) begin start = 1'b1; key_len = 2'd3; end
            if (poke && cyc == 7) begin start = 1'b0; key_len = v.kl; end
            if (err) err_seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", cyc, exp_cyc);
        chk("busy_at_done", busy, 0);
        chk("key_ready_at_done", key_ready, 1);
        chk("num_rounds", num_rounds, nr);
        chk("sbox_requests", sv_cnt, v.nsb);
        chk("no_err_while_busy", err_seen, 0);
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        chk("key_ready_held", key_ready, 1);
        for (int r = 0; r <= nr; r++) begin
            rk_idx = 4'(r);
            #1;
            chk($sformatf("rk_data[%0d]", r), rk_data, sbq.pop_front());
        end
        rk_idx = 4'(nr + 1);
        #1;
        chk("rk_data_out_of_range", rk_data, 0);
        rk_idx = v.idx;
        #1;
        chk("rk_data_vector", rk_data, v.rk);
`ifdef AES_KEYEXP_STREAM_EN
        chk("stream_pulses", st_cnt, nr + 1);
        chk("stream_drained", stq.size(), 0);
`endif
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] x, inv;
            x   = 8'(a);
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, x);
            end
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        tbl[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10, 4'd10,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 8, 4'd12,
                   128'he98ba06f448c773c8ecc720401002202};
        tbl[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 13, 4'd14,
                   128'hfe4890d1e6188d0b046df344706c631e};
        tbl[3] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10, 4'd0,
                   128'h2b7e151628aed2a6abf7158809cf4f3c};

        reset = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_idx = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_sub_valid", sub_valid, 0);
        chk("rst_sub_in", sub_in, 0);
        chk("rst_num_rounds", num_rounds, 10);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run_and_check(tbl[i], i == 3);

        // invalid key length while idle
        @(negedge clk);
        key_len = 2'd3;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_key_ready_kept", key_ready, 1);
        @(posedge clk); #1;
        chk("err_pulse_end", err, 0);
        chk("err_busy_after", busy, 0);

        // abort an AES-256 run with reset colliding with start
        ref_expand(tbl[2].kl, tbl[2].key);
        for (int r = 0; r <= rnr; r++) stq.push_back({4'(r), rk_of(r)});
        @(negedge clk);
        key_len = tbl[2].kl;
        key     = tbl[2].key;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        start   = 1'b1;
        key_len = 2'd0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_key_ready", key_ready, 0);
        chk("abort_sub_valid", sub_valid, 0);
        chk("abort_sub_in", sub_in, 0);
        chk("abort_num_rounds", num_rounds, 10);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        stq.delete();
        @(posedge clk); #1;
        chk("abort_stays_idle", busy, 0);
        chk("abort_not_ready", key_ready, 0);

        run_and_check(tbl[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
